// File: rtl/alu_op_sequencer.sv
// Steps one operand pair through ALU opcodes 0..OP_LAST and captures each {carry,y} into an 8-entry buffer.
// Optional result checker enabled by defining ALU_SEQ_CHECK_EN; err_count/err_flag read 0 without it.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int OP_LAST       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [3:0] alu_y,
    input  logic       alu_carry,
    input  logic [2:0] rd_idx,
    output logic [3:0] rd_y,
    output logic       rd_carry,
    output logic [3:0] err_count,
    output logic       err_flag
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

    state_t          state_q;
    logic [3:0]      aluA_q;
    logic [3:0]      aluB_q;
    logic [2:0]      opcode_q;
    logic [CW-1:0]   settleCnt_q;
    logic            busy_q;
    logic            done_q;
    logic [7:0][3:0] resY_q;
    logic [7:0]      resC_q;

`ifdef ALU_SEQ_CHECK_EN
    logic [3:0] errCount_q;
    logic [3:0] errCount_d;
    logic       errFlag_q;
    logic       errFlag_d;
    logic [4:0] expected;

    // Reference {carry,y} for the current opcode, from the latched operands.
    always_comb begin
        expected = 5'd0;
        case (opcode_q)
            3'd0:    expected = {1'b0, aluA_q} + {1'b0, aluB_q};
            3'd1:    expected = {1'b0, aluA_q} - {1'b0, aluB_q};
            3'd2:    expected = {1'b0, aluA_q & aluB_q};
            3'd3:    expected = {1'b0, aluA_q | aluB_q};
            3'd4:    expected = {1'b0, aluA_q ^ aluB_q};
            3'd5:    expected = {aluA_q[3], aluA_q[2:0], 1'b0};
            3'd6:    expected = {aluA_q[0], 1'b0, aluA_q[3:1]};
            default: expected = 5'd0;
        endcase
    end

    always_comb begin
        errCount_d = errCount_q;
        errFlag_d  = errFlag_q;
        if (state_q == IDLE && start && !done_q) begin
            errCount_d = 4'd0;
            errFlag_d  = 1'b0;
        end else if (state_q == CAPTURE && expected != {alu_carry, alu_y}) begin
            errFlag_d = 1'b1;
            if (errCount_q != 4'hF) begin
                errCount_d = errCount_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errCount_q <= 4'd0;
            errFlag_q  <= 1'b0;
        end else begin
            errCount_q <= errCount_d;
            errFlag_q  <= errFlag_d;
        end
    end

    assign err_count = errCount_q;
    assign err_flag  = errFlag_q;
`else
    assign err_count = 4'd0;
    assign err_flag  = 1'b0;
`endif

    // done_q is still high in the first IDLE cycle after a run, which blocks a start held through it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            aluA_q      <= 4'd0;
            aluB_q      <= 4'd0;
            opcode_q    <= 3'd0;
            settleCnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resY_q      <= '0;
            resC_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !done_q) begin
                        aluA_q      <= a_in;
                        aluB_q      <= b_in;
                        opcode_q    <= 3'd0;
                        settleCnt_q <= '0;
                        resY_q      <= '0;
                        resC_q      <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settleCnt_q == CW'(SETTLE_CYCLES - 1)) begin
                        state_q <= CAPTURE;
                    end else begin
                        settleCnt_q <= settleCnt_q + CW'(1);
                    end
                end
                CAPTURE: begin
                    resY_q[opcode_q] <= alu_y;
                    resC_q[opcode_q] <= alu_carry;
                    if (opcode_q == 3'(OP_LAST)) begin
                        state_q <= DONE;
                    end else begin
                        opcode_q    <= opcode_q + 3'd1;
                        settleCnt_q <= '0;
                        state_q     <= DRIVE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign alu_a      = aluA_q;
    assign alu_b      = aluB_q;
    assign alu_opcode = opcode_q;
    assign rd_y       = resY_q[rd_idx];
    assign rd_carry   = resC_q[rd_idx];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a default-parameter instance and a SETTLE_CYCLES=3/OP_LAST=2 instance.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] aIn;
    logic [3:0] bIn;
    logic [2:0] rdIdx;
    logic       sel;
    logic       corrupt;

    int vectors     = 0;
    int miscompares = 0;
    logic [4:0] expQ[$];

    always #5 clk = ~clk;

    // ALU behaviour written from the opcode table: {carry, y}
    function automatic logic [4:0] aluRef(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        case (op)
            3'd0:    r = 5'(a) + 5'(b);
            3'd1:    r = 5'(a) - 5'(b);
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {a[3], a[2:0], 1'b0};
            3'd6:    r = {a[0], 1'b0, a[3:1]};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    logic       busy1, done1, aluC1, rdC1, errFlag1, start1;
    logic [3:0] aluA1, aluB1, aluY1, rdY1, errCount1;
    logic [2:0] op1;
    logic       busy2, done2, aluC2, rdC2, errFlag2, start2;
    logic [3:0] aluA2, aluB2, aluY2, rdY2, errCount2;
    logic [2:0] op2;

    assign start1 = start & ~sel;
    assign start2 = start & sel;
    assign {aluC1, aluY1} = aluRef(op1, aluA1, aluB1) ^ ((corrupt && op1 == 3'd2) ? 5'b00001 : 5'b00000);
    assign {aluC2, aluY2} = aluRef(op2, aluA2, aluB2);

    alu_op_sequencer dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(aIn), .b_in(bIn),
        .busy(busy1), .done(done1), .alu_a(aluA1), .alu_b(aluB1), .alu_opcode(op1),
        .alu_y(aluY1), .alu_carry(aluC1), .rd_idx(rdIdx), .rd_y(rdY1), .rd_carry(rdC1),
        .err_count(errCount1), .err_flag(errFlag1)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3), .OP_LAST(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_in(aIn), .b_in(bIn),
        .busy(busy2), .done(done2), .alu_a(aluA2), .alu_b(aluB2), .alu_opcode(op2),
        .alu_y(aluY2), .alu_carry(aluC2), .rd_idx(rdIdx), .rd_y(rdY2), .rd_carry(rdC2),
        .err_count(errCount2), .err_flag(errFlag2)
    );

    logic       obsBusy, obsDone, obsC;
    logic [3:0] obsA, obsY;
    logic [2:0] obsOp;
    assign obsBusy = sel ? busy2 : busy1;
    assign obsDone = sel ? done2 : done1;
    assign obsA    = sel ? aluA2 : aluA1;
    assign obsOp   = sel ? op2 : op1;
    assign obsY    = sel ? rdY2 : rdY1;
    assign obsC    = sel ? rdC2 : rdC1;

    // Runs one sequence, checking timing edge by edge, then pops the scoreboard against the buffer.
    task automatic applyStimulus(input int settle, input int opLast, input logic [3:0] a, input logic [3:0] b,
                                 input int repulseAt, input bit startAtDone);
        int total;
        int expOp;
        logic [4:0] exp;
        total = (opLast + 1) * (settle + 1) + 1;
        @(negedge clk);
        aIn = a; bIn = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; aIn = ~a; bIn = ~b;
        vectors++;
        if (obsBusy !== 1'b1 || obsA !== a) begin
            miscompares++;
            $display("[TB] FAIL accept: busy=%b alu_a=%h required busy=1 alu_a=%h", obsBusy, obsA, a);
        end
        for (int n = 1; n <= total; n++) begin
            if (n == repulseAt) begin
                start = 1'b1; aIn = 4'h5; bIn = 4'h5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            expOp = n / (settle + 1);
            if (expOp > opLast) expOp = opLast;
            vectors++;
            if (obsDone !== (n == total) || obsBusy !== (n < total) || obsOp !== 3'(expOp)) begin
                miscompares++;
                $display("[TB] FAIL edge%0d: done=%b busy=%b op=%0d required done=%b busy=%b op=%0d",
                         n, obsDone, obsBusy, obsOp, (n == total), (n < total), expOp);
            end
        end
        if (startAtDone) begin
            start = 1'b1; aIn = 4'h9; bIn = 4'h9;
            @(posedge clk); #1;
            start = 1'b0;
            vectors++;
            if (obsBusy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL start_in_done: busy=%b required 0", obsBusy);
            end
        end
        for (int i = 0; i < 8; i++) begin
            rdIdx = 3'(i);
            #1;
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL scoreboard_empty idx%0d: got {%b,%h} required an entry", i, obsC, obsY);
            end else begin
                exp = expQ.pop_front();
                if ({obsC, obsY} !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL buf idx%0d: got {%b,%h} required {%b,%h}", i, obsC, obsY, exp[4], exp[3:0]);
                end
            end
        end
    endtask

    task automatic pushModel(input int opLast, input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < 8; i++) expQ.push_back(i <= opLast ? aluRef(3'(i), a, b) : 5'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; aIn = 4'h0; bIn = 4'h0; rdIdx = 3'd0; sel = 1'b0; corrupt = 1'b0;
        #12;
        vectors++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || aluA1 !== 4'h0 || aluB1 !== 4'h0 || op1 !== 3'd0 ||
            rdY1 !== 4'h0 || rdC1 !== 1'b0 || errCount1 !== 4'h0 || errFlag1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset: busy=%b done=%b a=%h b=%h op=%0d y=%h c=%b err=%h flag=%b required all 0",
                     busy1, done1, aluA1, aluB1, op1, rdY1, rdC1, errCount1, errFlag1);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [4:0] tbl[8];
        tbl = '{5'h04, 5'h02, 5'h01, 5'h03, 5'h02, 5'h06, 5'h11, 5'h00};
        for (int i = 0; i < 8; i++) expQ.push_back(tbl[i]);
        applyStimulus(1, 6, 4'h3, 4'h1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        aIn = 4'h3; bIn = 4'h1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || op1 !== 3'd0 || aluA1 !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: busy=%b done=%b op=%0d a=%h required 0 0 0 0", busy1, done1, op1, aluA1);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rdIdx = 3'(i); #1;
            vectors++;
            if ({rdC1, rdY1} !== 5'd0) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_buf idx%0d: got {%b,%h} required {0,0}", i, rdC1, rdY1);
            end
        end
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            vectors++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_idle cyc%0d: done=%b busy=%b required 0 0", n, done1, busy1);
            end
        end
    endtask

    task automatic test_wrap();
        pushModel(6, 4'hF, 4'h1);
        expQ[0] = 5'h10; expQ[1] = 5'h0E; expQ[5] = 5'h1E; expQ[6] = 5'h17;
        applyStimulus(1, 6, 4'hF, 4'h1, 0, 1'b0);
    endtask

    task automatic test_checker();
        logic [3:0] expCount;
        logic       expFlag;
`ifdef ALU_SEQ_CHECK_EN
        expCount = 4'd1; expFlag = 1'b1;
`else
        expCount = 4'd0; expFlag = 1'b0;
`endif
        corrupt = 1'b1;
        pushModel(6, 4'h1, 4'h2);
        expQ[1] = 5'h1F;
        expQ[2] = aluRef(3'd2, 4'h1, 4'h2) ^ 5'b00001;
        applyStimulus(1, 6, 4'h1, 4'h2, 0, 1'b0);
        vectors++;
        if (errCount1 !== expCount || errFlag1 !== expFlag) begin
            miscompares++;
            $display("[TB] FAIL checker_bad: err_count=%0d err_flag=%b required %0d %b", errCount1, errFlag1, expCount, expFlag);
        end
        corrupt = 1'b0;
        pushModel(6, 4'h1, 4'h2);
        applyStimulus(1, 6, 4'h1, 4'h2, 0, 1'b0);
        vectors++;
        if (errCount1 !== 4'd0 || errFlag1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL checker_good: err_count=%0d err_flag=%b required 0 0", errCount1, errFlag1);
        end
    endtask

    task automatic test_back_to_back();
        pushModel(6, 4'hA, 4'h6);
        applyStimulus(1, 6, 4'hA, 4'h6, 4, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            vectors++;
            if (done1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL second_done cyc%0d: done=%b required 0", n, done1);
            end
        end
    endtask

    task automatic test_params();
        sel = 1'b1;
        pushModel(2, 4'h3, 4'h1);
        applyStimulus(3, 2, 4'h3, 4'h1, 0, 1'b0);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_run();
        test_wrap();
        test_checker();
        test_back_to_back();
        test_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Hardware driver for the 4-bit ALU. It walks a single operand pair through ALU opcodes 0..OP_LAST, holding each opcode for a settle window, then captures Y/carry into an 8-entry result buffer. Host logic reads the buffer back by index. It sits on the initiator side of the ALU's A/B/opcode interface, in place of a bench stimulus process, and adds an optional built-in result checker.

## Interface
- SETTLE_CYCLES, 1, cycles each opcode is driven before capture; legal range ≥1
- OP_LAST, 6, last opcode issued; legal range 0..7
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- a_in, b_in  in  4  operands, latched when start is accepted
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse at end of run
- alu_a, alu_b  out  4  to ALU A/B (registered)
- alu_opcode  out  3  to ALU opcode (registered)
- alu_y  in  4  ALU result
- alu_carry  in  1  ALU carry
- rd_idx  in  3  result buffer read index
- rd_y  out  4  res_y[rd_idx], combinational read
- rd_carry  out  1  res_c[rd_idx], combinational read
- err_count  out  4  mismatch count, saturating at 15 (see Configuration)
- err_flag  out  1  sticky mismatch flag (see Configuration)

## Operation
- FSM states: IDLE, DRIVE, CAPTURE, DONE.
- IDLE + start: latch a_in/b_in into alu_a/alu_b; set alu_opcode=0; clear all 8 buffer entries, err_count and err_flag; go to DRIVE.
- DRIVE: hold alu_* for SETTLE_CYCLES cycles (internal counter), then go to CAPTURE.
- CAPTURE: write alu_y and alu_carry into entry [alu_opcode].
  - If alu_opcode==OP_LAST, go to DONE.
  - Otherwise increment alu_opcode and go to DRIVE.
- DONE: done=1 for one cycle, then IDLE. alu_* hold their last values in IDLE.
- start is ignored while busy. start asserted in the DONE cycle is also ignored.
- Entries above OP_LAST stay 0 after a run. Reads during a run return partially filled contents.
- ALU contract, used by the checker:
  - 000 ADD: {c,y}=A+B
  - 001 SUB: {c,y}={0,A}-{0,B}; c=1 means borrow
  - 010 AND, 011 OR, 100 XOR: c=0
  - 101 SHL: y=A<<1, c=A[3]
  - 110 SHR: y=A>>1, c=A[0]
  - 111: y=0, c=0

## Timing
- Reset values: alu_a=alu_b=0, alu_opcode=0, busy=0, done=0, all buffer entries 0, err_count=0, err_flag=0, FSM in IDLE.
- Each opcode occupies SETTLE_CYCLES+1 cycles.
- done rises (OP_LAST+1)*(SETTLE_CYCLES+1)+1 clock edges after the start-sampling edge. With defaults this is 15.
- busy falls in the same cycle done rises.
- rst asserted mid-run: immediate return to reset values; done does not pulse; the run is not resumed.
- Capture samples alu_y/alu_carry at the rising edge that ends the CAPTURE cycle. The ALU is combinational and must settle within SETTLE_CYCLES.

## Configuration
- ALU_SEQ_CHECK_EN defined:
  - On each CAPTURE, compute the expected {c,y} per the ALU contract from the latched operands and alu_opcode, and compare it against alu_y/alu_carry.
  - On mismatch: err_count increments (saturating at 15) and err_flag sets (sticky until start or rst).
- ALU_SEQ_CHECK_EN undefined: the checker is not built; err_count and err_flag are tied to 0. Ports are present in both builds.

## Test plan
- Reset mid-run (rst at cycle 5 after start) -> busy=0, done never pulses, all rd_y/rd_carry=0, alu_opcode=0.
- A=3, B=1, defaults -> alu_opcode steps 0..6, each held 2 cycles; done at edge 15. Buffer idx0..6 {c,y}: {0,4}, {0,2}, {0,1}, {0,3}, {0,2}, {0,6}, {1,1}.
- A=F, B=1 -> idx0 {1,0}, idx1 {0,E}, idx5 {1,E}, idx6 {1,7}; entry 7 stays 0.
- A=1, B=2 -> idx1 {1,F}. With ALU_SEQ_CHECK_EN and the bench ALU model corrupting y on opcode 2 -> err_count=1, err_flag=1; a second run with a correct model -> err_count=0.
- start pulsed again at cycle 4 of a run -> ignored, run completes normally at edge 15, no second done.
- SETTLE_CYCLES=3, OP_LAST=2, A=3, B=1 -> opcodes 0..2, each held 4 cycles; done at edge 13; idx3..7 remain 0.
